// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encoding,
// datapath select codes, opcodes and the control-word struct.
package multicycle_control_fsm_pkg;

  // FSM state encoding
  localparam int         STATE_W   = 3;
  localparam logic [2:0] S_IF      = 3'd0;
  localparam logic [2:0] S_ID      = 3'd1;
  localparam logic [2:0] S_EX      = 3'd2;
  localparam logic [2:0] S_EX_BR   = 3'd3;
  localparam logic [2:0] S_EX_BT   = 3'd4;
  localparam logic [2:0] S_MEM     = 3'd5;
  localparam logic [2:0] S_WB      = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  // ALU operand A select
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_RS1    = 2'b01;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

  // ALU operand B select
  localparam logic [1:0] SRC_B_RS2    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;

  // Operation class handed to ALUControlUnit
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_BR    = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  // Register file write-back source
  localparam logic [1:0] WB_ALUOUT    = 2'b00;
  localparam logic [1:0] WB_MDR       = 2'b01;
  localparam logic [1:0] WB_PC        = 2'b10;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

  // One cycle's worth of datapath control
  typedef struct packed {
    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
    logic       reg_write;
    logic [1:0] wb_src;
  } ctrl_t;

  // Opcodes that take the generic EX path out of ID
  function automatic logic goes_to_ex(input logic [6:0] op);
    return (op == OP_ARITH) || (op == OP_ARITH_IMM) || (op == OP_LOAD) ||
           (op == OP_STORE) || (op == OP_JAL)       || (op == OP_JALR);
  endfunction

  // Memory-access opcodes that continue from EX into MEM
  function automatic logic is_mem_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// Cycle and retired-instruction counters. Both wrap modulo 2^CNT_W.
module mc_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             retire,
  input  logic             freeze,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  // Cycle counter stops advancing once the core is frozen (halted)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               cycle_cnt <= '0;
    else if (en && !freeze)  cycle_cnt <= cycle_cnt + CNT_W'(1);
  end

  // Retired counter advances once per completed instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               retired_cnt <= '0;
    else if (en && retire)   retired_cnt <= retired_cnt + CNT_W'(1);
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main control FSM of the multi-cycle RV32I core. Walks each instruction
// through IF/ID/EX/MEM/WB, decodes datapath selects per state, watches the
// variable-latency memory handshake and halts on ECALL or memory timeout.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int MEM_TO = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_ctrl_op,
  output logic             reg_write,
  output logic [1:0]       wb_src,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int WAIT_W = $clog2(MEM_TO + 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               mem_wait_st;
  logic               timeout;
  logic               retire;
  logic               mem_err_q;
  ctrl_t              ctrl, ctrl_out;

  // Only IF and MEM talk to memory; mem_ready elsewhere is ignored
  assign mem_wait_st = (state == S_IF) || (state == S_MEM);
  // Last permitted waiting cycle without mem_ready: give up and halt
  assign timeout     = mem_wait_st && !mem_ready &&
                       (wait_cnt == WAIT_W'(MEM_TO - 1));

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IF: begin
        if (mem_ready)    state_nxt = S_ID;
        else if (timeout) state_nxt = S_HALT;
      end
      S_ID: begin
        if (goes_to_ex(opcode))        state_nxt = S_EX;
        else if (opcode == OP_BRANCH)  state_nxt = S_EX_BR;
        else if (opcode == OP_SYSTEM)  state_nxt = halt_req ? S_HALT : S_IF;
        else                           state_nxt = S_IF;  // unknown: skip
      end
      S_EX: begin
        if (is_mem_op(opcode))                                   state_nxt = S_MEM;
        else if ((opcode == OP_ARITH) || (opcode == OP_ARITH_IMM)) state_nxt = S_WB;
        else                                                     state_nxt = S_IF;
      end
      S_EX_BR: state_nxt = bcond ? S_EX_BT : S_IF;
      S_EX_BT: state_nxt = S_IF;
      S_MEM: begin
        if (mem_ready)    state_nxt = (opcode == OP_LOAD) ? S_WB : S_IF;
        else if (timeout) state_nxt = S_HALT;
      end
      S_WB:    state_nxt = S_IF;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IF;
    endcase
  end

  // Per-state datapath control; anything not driven stays 0
  always_comb begin
    ctrl = '0;
    case (state)
      S_IF: begin
        ctrl.mem_read = 1'b1;
        if (mem_ready) begin
          ctrl.ir_write    = 1'b1;
          ctrl.pc_write    = 1'b1;
          ctrl.alu_src_a   = SRC_A_PC;
          ctrl.alu_src_b   = SRC_B_FOUR;
          ctrl.alu_ctrl_op = ALU_OP_ADD;
        end
      end
      S_EX: begin
        case (opcode)
          OP_ARITH: begin
            ctrl.alu_src_a   = SRC_A_RS1;
            ctrl.alu_src_b   = SRC_B_RS2;
            ctrl.alu_ctrl_op = ALU_OP_FUNCT;
          end
          OP_ARITH_IMM: begin
            ctrl.alu_src_a   = SRC_A_RS1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_OP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl.alu_src_a   = SRC_A_RS1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_OP_ADD;
          end
          // PC already holds OLD_PC+4, so the link value comes straight from PC
          OP_JAL, OP_JALR: begin
            ctrl.alu_src_a   = (opcode == OP_JAL) ? SRC_A_OLD_PC : SRC_A_RS1;
            ctrl.alu_src_b   = SRC_B_IMM;
            ctrl.alu_ctrl_op = ALU_OP_ADD;
            ctrl.pc_write    = 1'b1;
            ctrl.reg_write   = 1'b1;
            ctrl.wb_src      = WB_PC;
          end
          default: ;
        endcase
      end
      S_EX_BR: begin
        ctrl.alu_src_a   = SRC_A_RS1;
        ctrl.alu_src_b   = SRC_B_RS2;
        ctrl.alu_ctrl_op = ALU_OP_BR;
      end
      S_EX_BT: begin
        ctrl.alu_src_a   = SRC_A_OLD_PC;
        ctrl.alu_src_b   = SRC_B_IMM;
        ctrl.alu_ctrl_op = ALU_OP_ADD;
        ctrl.pc_write    = 1'b1;
      end
      S_MEM: begin
        ctrl.i_or_d    = 1'b1;
        ctrl.mem_read  = (opcode == OP_LOAD);
        ctrl.mem_write = (opcode == OP_STORE);
      end
      S_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.wb_src    = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
      end
      default: ;  // ID and HALT drive nothing
    endcase
  end

  // Reset forces every control line low combinationally, so nothing
  // partial reaches the datapath once reset rises
  assign ctrl_out    = reset ? '0 : ctrl;
  assign pc_write    = ctrl_out.pc_write;
  assign pc_source   = ctrl_out.pc_source;
  assign i_or_d      = ctrl_out.i_or_d;
  assign mem_read    = ctrl_out.mem_read;
  assign mem_write   = ctrl_out.mem_write;
  assign ir_write    = ctrl_out.ir_write;
  assign alu_src_a   = ctrl_out.alu_src_a;
  assign alu_src_b   = ctrl_out.alu_src_b;
  assign alu_ctrl_op = ctrl_out.alu_ctrl_op;
  assign reg_write   = ctrl_out.reg_write;
  assign wb_src      = ctrl_out.wb_src;
  assign halted      = !reset && (state == S_HALT);
  assign mem_err     = !reset && mem_err_q;

  // An instruction retires on its final hop back to IF, or ID->HALT (ECALL)
  assign retire = ((state != S_IF) && (state_nxt == S_IF)) ||
                  ((state == S_ID) && (state_nxt == S_HALT));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IF;
    else       state <= state_nxt;
  end

  // Memory wait counter: cleared on any state change, counts idle IF/MEM cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  wait_cnt <= '0;
    else if ((state_nxt != state) || !mem_wait_st) wait_cnt <= '0;
    else                                        wait_cnt <= wait_cnt + WAIT_W'(1);
  end

  // Sticky memory-timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        mem_err_q <= 1'b0;
    else if (timeout) mem_err_q <= 1'b1;
  end

  mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
    .clk         (clk),
    .reset       (reset),
    .en          (1'b1),
    .retire      (retire),
    .freeze      (state == S_HALT),
    .cycle_cnt   (cycle_cnt),
    .retired_cnt (retired_cnt)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: each scenario queues per-cycle
// stimulus with its expected control word and counters, then replays it.
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        bcond = 1'b0, halt_req = 1'b0, mem_ready = 1'b0;
  logic        pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write;
  logic [1:0]  alu_src_a, alu_src_b, alu_ctrl_op, wb_src;
  logic        reg_write, halted, mem_err;
  logic [31:0] cycle_cnt, retired_cnt;

  multicycle_control_fsm #(.CNT_W(32), .MEM_TO(64)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
    .halt_req(halt_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl_op(alu_ctrl_op), .reg_write(reg_write),
    .wb_src(wb_src), .halted(halted), .mem_err(mem_err),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  // Observed control word; bit 1 = halted, bit 0 = mem_err
  logic [16:0] obs;
  assign obs = {pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
                alu_src_a, alu_src_b, alu_ctrl_op, reg_write, wb_src, halted, mem_err};

  function automatic logic [16:0] cv(input logic pcw, pcs, iod, mr, mw, irw,
                                     input logic [1:0] a, b, op,
                                     input logic rw, input logic [1:0] wb,
                                     input logic h, e);
    return {pcw, pcs, iod, mr, mw, irw, a, b, op, rw, wb, h, e};
  endfunction

  localparam logic [16:0] C_ZERO    = 17'd0;
  localparam logic [16:0] C_IF_WAIT = cv(0,0,0,1,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_IF_RDY  = cv(1,0,0,1,0,1, 2'b00,2'b01,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_EX_ADD  = cv(0,0,0,0,0,0, 2'b01,2'b00,2'b10, 0,2'b00, 0,0);
  localparam logic [16:0] C_EX_ADDI = cv(0,0,0,0,0,0, 2'b01,2'b10,2'b10, 0,2'b00, 0,0);
  localparam logic [16:0] C_EX_LS   = cv(0,0,0,0,0,0, 2'b01,2'b10,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_EX_JAL  = cv(1,0,0,0,0,0, 2'b10,2'b10,2'b00, 1,2'b10, 0,0);
  localparam logic [16:0] C_EX_JALR = cv(1,0,0,0,0,0, 2'b01,2'b10,2'b00, 1,2'b10, 0,0);
  localparam logic [16:0] C_EX_BR   = cv(0,0,0,0,0,0, 2'b01,2'b00,2'b01, 0,2'b00, 0,0);
  localparam logic [16:0] C_EX_BT   = cv(1,0,0,0,0,0, 2'b10,2'b10,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_MEM_LD  = cv(0,0,1,1,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_MEM_ST  = cv(0,0,1,0,1,0, 2'b00,2'b00,2'b00, 0,2'b00, 0,0);
  localparam logic [16:0] C_WB_ALU  = cv(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,2'b00, 0,0);
  localparam logic [16:0] C_WB_MDR  = cv(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 1,2'b01, 0,0);
  localparam logic [16:0] C_HALT    = cv(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 1,0);
  localparam logic [16:0] C_HALT_E  = cv(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 0,2'b00, 1,1);

  typedef struct {
    logic [6:0]  op;
    logic        rdy, bc, hr;
    logic [16:0] ctl;
    logic [31:0] cyc, ret;
  } step_t;

  step_t sb_q[$];
  int    exp_cyc;
  int    n_run = 0, n_fail = 0;

  // Queue one cycle of stimulus plus its expectation; cycle count freezes in HALT
  task automatic push(input logic [6:0] op, input logic rdy, bc, hr,
                      input logic [16:0] ctl, input int ret);
    step_t s;
    s.op = op; s.rdy = rdy; s.bc = bc; s.hr = hr; s.ctl = ctl;
    s.cyc = 32'(exp_cyc); s.ret = 32'(ret);
    if (!ctl[1]) exp_cyc++;
    sb_q.push_back(s);
  endtask

  // Called at a negedge; returns at a negedge with reset released, state IF
  task automatic do_reset();
    opcode = '0; bcond = 0; halt_req = 0; mem_ready = 0;
    reset = 1'b1;
    #1;
    @(negedge clk);
    reset = 1'b0;
    exp_cyc = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    opcode = OP_ARITH; mem_ready = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_run++;
      if (obs !== C_ZERO) begin
        n_fail++; $display("FAIL reset_ctl cyc %0d: got %b want %b", i, obs, C_ZERO);
      end
      n_run++;
      if (cycle_cnt !== 32'd0 || retired_cnt !== 32'd0) begin
        n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", cycle_cnt, retired_cnt);
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_add_store();
    step_t s;
    do_reset();
    push(OP_ARITH, 1,0,0, C_IF_RDY, 0);  push(OP_ARITH, 1,0,0, C_ZERO, 0);
    push(OP_ARITH, 1,0,0, C_EX_ADD, 0);  push(OP_ARITH, 1,0,0, C_WB_ALU, 0);
    push(OP_STORE, 1,0,0, C_IF_RDY, 1);  push(OP_STORE, 1,0,0, C_ZERO, 1);
    push(OP_STORE, 1,0,0, C_EX_LS, 1);   push(OP_STORE, 1,0,0, C_MEM_ST, 1);
    push(OP_ARITH_IMM, 1,0,0, C_IF_RDY, 2); push(OP_ARITH_IMM, 1,0,0, C_ZERO, 2);
    push(OP_ARITH_IMM, 1,0,0, C_EX_ADDI, 2); push(OP_ARITH_IMM, 1,0,0, C_WB_ALU, 2);
    push(OP_ARITH, 0,0,0, C_IF_WAIT, 3);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL add_store ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL add_store cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL add_store retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  task automatic test_load();
    step_t s;
    do_reset();
    push(OP_LOAD, 0,0,0, C_IF_WAIT, 0); push(OP_LOAD, 0,0,0, C_IF_WAIT, 0);
    push(OP_LOAD, 1,0,0, C_IF_RDY, 0);  push(OP_LOAD, 1,0,0, C_ZERO, 0);
    push(OP_LOAD, 1,0,0, C_EX_LS, 0);   push(OP_LOAD, 0,0,0, C_MEM_LD, 0);
    push(OP_LOAD, 1,0,0, C_MEM_LD, 0);  push(OP_LOAD, 1,0,0, C_WB_MDR, 0);
    push(OP_LOAD, 0,0,0, C_IF_WAIT, 1);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL load ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL load cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL load retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    step_t s;
    do_reset();
    push(OP_BRANCH, 1,0,0, C_IF_RDY, 0); push(OP_BRANCH, 1,1,0, C_ZERO, 0);
    push(OP_BRANCH, 1,0,0, C_EX_BR, 0);  push(OP_BRANCH, 1,0,0, C_IF_RDY, 1);
    push(OP_BRANCH, 1,0,0, C_ZERO, 1);   push(OP_BRANCH, 1,1,0, C_EX_BR, 1);
    push(OP_BRANCH, 1,0,0, C_EX_BT, 1);  push(OP_BRANCH, 0,0,0, C_IF_WAIT, 2);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL branch ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL branch cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL branch retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  task automatic test_jump();
    step_t s;
    do_reset();
    push(OP_JAL, 1,0,0, C_IF_RDY, 0);  push(OP_JAL, 1,0,0, C_ZERO, 0);
    push(OP_JAL, 1,0,0, C_EX_JAL, 0);  push(OP_JALR, 1,0,0, C_IF_RDY, 1);
    push(OP_JALR, 1,0,0, C_ZERO, 1);   push(OP_JALR, 1,0,0, C_EX_JALR, 1);
    push(OP_JALR, 0,0,0, C_IF_WAIT, 2);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL jump ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL jump cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL jump retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  // ECALL without halt, unknown opcode (halt_req must be ignored), then halting ECALL
  task automatic test_ecall();
    step_t s;
    do_reset();
    push(OP_SYSTEM, 1,0,0, C_IF_RDY, 0); push(OP_SYSTEM, 1,0,0, C_ZERO, 0);
    push(7'h7f, 1,0,1, C_IF_RDY, 1);     push(7'h7f, 1,0,1, C_ZERO, 1);
    push(OP_SYSTEM, 1,0,1, C_IF_RDY, 2); push(OP_SYSTEM, 1,0,1, C_ZERO, 2);
    push(OP_SYSTEM, 1,0,1, C_HALT, 3);   push(OP_SYSTEM, 1,0,0, C_HALT, 3);
    push(OP_ARITH, 1,0,0, C_HALT, 3);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL ecall ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL ecall cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL ecall retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    step_t s;
    do_reset();
    for (int k = 0; k < 64; k++) push(OP_LOAD, 0,0,0, C_IF_WAIT, 0);
    push(OP_LOAD, 0,0,0, C_HALT_E, 0);
    push(OP_LOAD, 1,0,0, C_HALT_E, 0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL timeout ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL timeout cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      n_run++; if (retired_cnt !== s.ret) begin n_fail++; $display("FAIL timeout retired_cnt step %0d: got %0d want %0d", i, retired_cnt, s.ret); end
      @(negedge clk);
    end
  endtask

  // Reset while a load waits in MEM, then the fetch restarts from IF
  task automatic test_reset_mid_mem();
    step_t s;
    do_reset();
    push(OP_LOAD, 1,0,0, C_IF_RDY, 0); push(OP_LOAD, 1,0,0, C_ZERO, 0);
    push(OP_LOAD, 1,0,0, C_EX_LS, 0);  push(OP_LOAD, 0,0,0, C_MEM_LD, 0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL mid_mem ctl step %0d: got %b want %b", i, obs, s.ctl); end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    n_run++;
    if (obs !== C_ZERO) begin n_fail++; $display("FAIL mid_mem reset_ctl: got %b want %b", obs, C_ZERO); end
    n_run++;
    if (cycle_cnt !== 32'd0) begin n_fail++; $display("FAIL mid_mem reset_cycle_cnt: got %0d want 0", cycle_cnt); end
    do_reset();
    push(OP_LOAD, 0,0,0, C_IF_WAIT, 0); push(OP_LOAD, 1,0,0, C_IF_RDY, 0);
    push(OP_LOAD, 1,0,0, C_ZERO, 0);
    for (int i = 0; sb_q.size() > 0; i++) begin
      s = sb_q.pop_front();
      opcode = s.op; mem_ready = s.rdy; bcond = s.bc; halt_req = s.hr; #1;
      n_run++; if (obs !== s.ctl) begin n_fail++; $display("FAIL restart ctl step %0d: got %b want %b", i, obs, s.ctl); end
      n_run++; if (cycle_cnt !== s.cyc) begin n_fail++; $display("FAIL restart cycle_cnt step %0d: got %0d want %0d", i, cycle_cnt, s.cyc); end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_add_store();
    test_load();
    test_branch();
    test_jump();
    test_ecall();
    test_timeout();
    test_reset_mid_mem();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
